// File: rtl/kof_pkg.sv
`default_nettype none
// kof_pkg -- shared FSM states, winner codes and lane helpers for round_controller.
// Revision: 1.0
package kof_pkg;

   localparam int DMG_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INTRO     = 3'd1,
      ST_FIGHT     = 3'd2,
      ST_KO        = 3'd3,
      ST_MATCH_END = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_t;

   typedef struct packed {
      logic [DMG_W-1:0] p1;
      logic [DMG_W-1:0] p2;
   } lanes_t;

   function automatic lanes_t split_lanes(input logic [2*DMG_W-1:0] i_word);
      return lanes_t'(i_word);
   endfunction

endpackage
`default_nettype wire

// File: rtl/round_controller_if.sv
`default_nettype none
// round_controller_if -- match-sequencer bus (game inputs, Blood_Counter link, status).
// Revision: 1.0; time_left only exists when ROUND_TIMER_EN is defined.
interface round_controller_if #(
   parameter int DMG_W = 8
);
   logic               start;
   logic               frame_tick;
   logic               hit_p1;
   logic [DMG_W-1:0]   dmg_p1;
   logic               hit_p2;
   logic [DMG_W-1:0]   dmg_p2;
   logic [2*DMG_W-1:0] blood;
   logic               over;
   logic               keep;
   logic               fresh;
   logic [2*DMG_W-1:0] blood_dec;
   logic [2:0]         state;
   logic [1:0]         round;
   logic [1:0]         wins_p1;
   logic [1:0]         wins_p2;
   logic [1:0]         winner;
   logic               match_done;
`ifdef ROUND_TIMER_EN
   logic [12:0]        time_left;
`endif

   modport master (
      output start, frame_tick, hit_p1, dmg_p1, hit_p2, dmg_p2, blood, over,
      input  keep, fresh, blood_dec, state, round, wins_p1, wins_p2, winner,
      input  match_done
`ifdef ROUND_TIMER_EN
      , input time_left
`endif
   );

   modport slave (
      input  start, frame_tick, hit_p1, dmg_p1, hit_p2, dmg_p2, blood, over,
      output keep, fresh, blood_dec, state, round, wins_p1, wins_p2, winner,
      output match_done
`ifdef ROUND_TIMER_EN
      , output time_left
`endif
   );

endinterface
`default_nettype wire

// File: rtl/hit_accumulator.sv
`default_nettype none
// hit_accumulator -- one damage lane: saturating per-frame sum, flushed into a one-cycle decrement.
// Revision: 1.0
module hit_accumulator #(
   parameter int DMG_W = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_clr,
   input  wire logic             i_en,
   input  wire logic             i_flush,
   input  wire logic             i_hit,
   input  wire logic [DMG_W-1:0] i_dmg,
   output logic      [DMG_W-1:0] o_dec
);

   logic [DMG_W-1:0] r_pend;
   logic [DMG_W-1:0] r_dec;
   logic [DMG_W:0]   w_sum;
   logic [DMG_W-1:0] w_sat;
   logic [DMG_W-1:0] w_load;

   assign w_sum  = {1'b0, r_pend} + {1'b0, i_dmg};
   assign w_sat  = w_sum[DMG_W] ? {DMG_W{1'b1}} : w_sum[DMG_W-1:0];
   // A hit landing on the flush cycle seeds the next frame instead of joining this one.
   assign w_load = (i_en && i_hit) ? i_dmg : '0;
   assign o_dec  = r_dec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
         r_dec  <= '0;
      end else begin
         r_dec <= i_flush ? r_pend : '0;
         if (i_clr) begin
            r_pend <= '0;
         end else if (i_flush) begin
            r_pend <= w_load;
         end else if (i_en && i_hit) begin
            r_pend <= w_sat;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// round_controller -- intro/fight/KO round sequencer driving the Blood_Counter; optional ROUND_TIMER_EN adds a fight timer.
// Revision: 1.0
module round_controller #(
   parameter int INTRO_FRAMES  = 60,
   parameter int KO_FRAMES     = 90,
   parameter int ROUNDS_TO_WIN = 2,
   parameter int DMG_W         = 8
`ifdef ROUND_TIMER_EN
   , parameter int TIME_FRAMES = 5400
`endif
) (
   input wire logic          clk,
   input wire logic          reset,
   round_controller_if.slave bus
);
   import kof_pkg::*;

   localparam int MAX_ROUNDS = 2*ROUNDS_TO_WIN - 1;
   localparam int CNT_MAX    = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] c_intro_last = CNT_W'(INTRO_FRAMES - 1);
   localparam logic [CNT_W-1:0] c_ko_last    = CNT_W'(KO_FRAMES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
   localparam logic [1:0]       c_wins_goal  = 2'(ROUNDS_TO_WIN);
   localparam logic [1:0]       c_last_round = 2'(MAX_ROUNDS - 1);

   state_t           r_state, w_state_nxt;
   winner_t          r_winner, w_winner_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_round, w_round_nxt;
   logic [1:0]       r_wins1, w_wins1_nxt;
   logic [1:0]       r_wins2, w_wins2_nxt;
   logic             r_keep;
   logic             r_fresh;
   logic             r_match_done;
   logic             w_flush;
   logic             w_ko;
   logic             w_en;
   logic             w_clr;
   lanes_t           w_blood;
   logic [DMG_W-1:0] w_dec_p1;
   logic [DMG_W-1:0] w_dec_p2;
`ifdef ROUND_TIMER_EN
   logic [12:0]      r_time, w_time_nxt;
   logic             w_expire;
`endif

   assign w_blood = split_lanes(bus.blood);
   assign w_clr   = (w_state_nxt == ST_INTRO) && (r_state != ST_INTRO);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_round_nxt  = r_round;
      w_wins1_nxt  = r_wins1;
      w_wins2_nxt  = r_wins2;
      w_winner_nxt = r_winner;
      w_flush      = 1'b0;
      w_ko         = 1'b0;
      w_en         = 1'b0;
`ifdef ROUND_TIMER_EN
      w_time_nxt   = r_time;
      w_expire     = 1'b0;
`endif
      case (r_state)
         ST_IDLE, ST_MATCH_END: begin
            if (bus.start) begin
               w_state_nxt  = ST_INTRO;
               w_cnt_nxt    = '0;
               w_round_nxt  = 2'd0;
               w_wins1_nxt  = 2'd0;
               w_wins2_nxt  = 2'd0;
               w_winner_nxt = WIN_NONE;
            end
         end
         ST_INTRO: begin
            if (bus.frame_tick) begin
               if (r_cnt == c_intro_last) begin
                  w_state_nxt = ST_FIGHT;
                  w_cnt_nxt   = '0;
`ifdef ROUND_TIMER_EN
                  w_time_nxt  = 13'(TIME_FRAMES);
`endif
               end else begin
                  w_cnt_nxt = r_cnt + c_cnt_one;
               end
            end
         end
         ST_FIGHT: begin
`ifdef ROUND_TIMER_EN
            if (bus.frame_tick && (r_time != 13'd0)) begin
               w_time_nxt = r_time - 13'd1;
               w_expire   = (r_time == 13'd1);
            end
`endif
            // A KO decision suppresses the flush so blood freezes at the deciding value.
            if (bus.over) begin
               w_ko = 1'b1;
               if ((w_blood.p2 == '0) && (w_blood.p1 != '0)) begin
                  w_winner_nxt = WIN_P1;
                  w_wins1_nxt  = r_wins1 + 2'd1;
               end else if ((w_blood.p1 == '0) && (w_blood.p2 != '0)) begin
                  w_winner_nxt = WIN_P2;
                  w_wins2_nxt  = r_wins2 + 2'd1;
               end else begin
                  w_winner_nxt = WIN_DRAW;
               end
            end
`ifdef ROUND_TIMER_EN
            else if (w_expire) begin
               w_ko = 1'b1;
               if (w_blood.p1 > w_blood.p2) begin
                  w_winner_nxt = WIN_P1;
                  w_wins1_nxt  = r_wins1 + 2'd1;
               end else if (w_blood.p2 > w_blood.p1) begin
                  w_winner_nxt = WIN_P2;
                  w_wins2_nxt  = r_wins2 + 2'd1;
               end else begin
                  w_winner_nxt = WIN_DRAW;
               end
            end
`endif
            else begin
               w_en    = 1'b1;
               w_flush = bus.frame_tick;
            end
            if (w_ko) begin
               w_state_nxt = ST_KO;
               w_cnt_nxt   = '0;
            end
         end
         ST_KO: begin
            if (bus.frame_tick) begin
               if (r_cnt == c_ko_last) begin
                  w_cnt_nxt = '0;
                  if ((r_wins1 == c_wins_goal) || (r_wins2 == c_wins_goal) ||
                      (r_round == c_last_round)) begin
                     w_state_nxt = ST_MATCH_END;
                     if (r_wins1 > r_wins2) begin
                        w_winner_nxt = WIN_P1;
                     end else if (r_wins2 > r_wins1) begin
                        w_winner_nxt = WIN_P2;
                     end else begin
                        w_winner_nxt = WIN_DRAW;
                     end
                  end else begin
                     w_state_nxt = ST_INTRO;
                     w_round_nxt = r_round + 2'd1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + c_cnt_one;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_round      <= 2'd0;
         r_wins1      <= 2'd0;
         r_wins2      <= 2'd0;
         r_winner     <= WIN_NONE;
         r_keep       <= 1'b1;
         r_fresh      <= 1'b0;
         r_match_done <= 1'b0;
`ifdef ROUND_TIMER_EN
         r_time       <= 13'd0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_round      <= w_round_nxt;
         r_wins1      <= w_wins1_nxt;
         r_wins2      <= w_wins2_nxt;
         r_winner     <= w_winner_nxt;
         r_keep       <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_INTRO);
         r_fresh      <= w_flush;
         r_match_done <= (w_state_nxt == ST_MATCH_END);
`ifdef ROUND_TIMER_EN
         r_time       <= w_time_nxt;
`endif
      end
   end

   // Damage from P2's hits lands on P1's lane and vice versa.
   hit_accumulator #(.DMG_W(DMG_W)) u_acc_p1 (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_flush (w_flush),
      .i_hit   (bus.hit_p2),
      .i_dmg   (bus.dmg_p2),
      .o_dec   (w_dec_p1)
   );

   hit_accumulator #(.DMG_W(DMG_W)) u_acc_p2 (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_flush (w_flush),
      .i_hit   (bus.hit_p1),
      .i_dmg   (bus.dmg_p1),
      .o_dec   (w_dec_p2)
   );

   assign bus.keep       = r_keep;
   assign bus.fresh      = r_fresh;
   assign bus.blood_dec  = {w_dec_p1, w_dec_p2};
   assign bus.state      = r_state;
   assign bus.round      = r_round;
   assign bus.wins_p1    = r_wins1;
   assign bus.wins_p2    = r_wins2;
   assign bus.winner     = r_winner;
   assign bus.match_done = r_match_done;
`ifdef ROUND_TIMER_EN
   assign bus.time_left  = r_time;
`endif

endmodule
`default_nettype wire

// File: doc/round_controller.md
# round_controller

Match sequencer for the fighting-game core. Drives the Blood_Counter's `keep`, `fresh` and `blood_dec` inputs and reads back `blood` and `over`. Collects per-frame hit damage from both players into one decrement word per frame, runs the intro → fight → KO round sequence, and counts round wins up to match end.

## Interface
Parameters:
- `INTRO_FRAMES`, 60: frames `keep` stays high before a round becomes live.
- `KO_FRAMES`, 90: frames held in KO before the next round or match end.
- `ROUNDS_TO_WIN`, 2: round wins needed to take the match. Maximum rounds is `MAX_ROUNDS = 2*ROUNDS_TO_WIN-1`.
- `DMG_W`, 8: width of each player's damage lane. `blood_dec` is `2*DMG_W` = 16 bits.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  **asynchronous, active-low** reset.
- `start`  in  1  one-cycle pulse that starts a match.
- `frame_tick`  in  1  one-cycle frame strobe.
- `hit_p1`  in  1  P1 lands a hit on P2.
- `dmg_p1`  in  8  damage carried by `hit_p1`.
- `hit_p2`  in  1  P2 lands a hit on P1.
- `dmg_p2`  in  8  damage carried by `hit_p2`.
- `blood`  in  16  from Blood_Counter. `[15:8]` is P1, `[7:0]` is P2.
- `over`  in  1  from Blood_Counter. High when either lane is zero.
- `keep`  out  1  high: counter reloads to full.
- `fresh`  out  1  one-cycle apply strobe.
- `blood_dec`  out  16  `[15:8]` is damage applied to P1, `[7:0]` is damage applied to P2.
- `state`  out  3  current FSM state.
- `round`  out  2  round index, counting from 0.
- `wins_p1`  out  2  P1 round wins.
- `wins_p2`  out  2  P2 round wins.
- `winner`  out  2  0 = none, 1 = P1, 2 = P2, 3 = draw.
- `match_done`  out  1  high while in MATCH_END.

## Operation
- **FSM states:** IDLE(0), INTRO(1), FIGHT(2), KO(3), MATCH_END(4).
- **IDLE:** `start` moves to INTRO. On entry to INTRO: clear `wins_p1`, `wins_p2`, `round` and `winner`.
- **INTRO:**
  - `keep` = 1 throughout.
  - Counts `INTRO_FRAMES` `frame_tick`s, then moves to FIGHT.
  - Pending damage is cleared on entry.
- **FIGHT:**
  - `keep` = 0.
  - A hit with `hit_pN` = 1 adds `dmg_pN` into that lane's pending register. The add saturates at 255.
  - Each lane is independent, so simultaneous hits from both players are both kept.
- **Frame flush:** on `frame_tick` in FIGHT, the next cycle has `fresh` = 1 and `blood_dec` = {pending damage on P1, pending damage on P2}. Pending registers are then cleared.
  - A hit arriving in the same cycle as the flush is loaded into the freshly cleared pending register. It is never lost and never double-counted.
  - Outside the `fresh` cycle, `blood_dec` = 0.
- **KO detection:** the first cycle with `over` = 1 in FIGHT moves to KO.
  - `blood[7:0]` = 0 and `blood[15:8]` ≠ 0 gives `winner` = 1 and increments `wins_p1`.
  - `blood[15:8]` = 0 and `blood[7:0]` ≠ 0 gives `winner` = 2 and increments `wins_p2`.
  - Both lanes zero gives `winner` = 3 (draw) with no increment.
- **KO:**
  - `keep` = 0 and `fresh` = 0, so blood stays frozen.
  - `hit_*` inputs are ignored.
  - After `KO_FRAMES` ticks: if either wins counter equals `ROUNDS_TO_WIN`, or `round` = `MAX_ROUNDS-1`, go to MATCH_END. Otherwise increment `round` and go to INTRO.
- **MATCH_END:**
  - `winner` is the side with more wins; equal wins gives 3.
  - `match_done` = 1.
  - `start` restarts the match via INTRO, clearing wins and round.
- `start` in INTRO, FIGHT or KO is ignored.

## Timing
- **Reset values:**
  - `state` = IDLE, `keep` = 1, `fresh` = 0, `blood_dec` = 0.
  - `round`, `wins_p1`, `wins_p2`, `winner` = 0; `match_done` = 0.
  - Pending registers and frame counters = 0.
- **Reset mid-operation:** asserting `reset` (low) at any point forces the reset values immediately, whatever the state.
- **Registered outputs:** all outputs come from registers, with no combinational path from any input.
- **Flush latency:** `fresh` is asserted exactly 1 cycle after `frame_tick`, for 1 cycle.
- **KO latency:** the transition to KO and the `wins` update happen 1 cycle after `over` is first seen. `fresh` is not asserted again after the KO decision.
- **Frame counting:** a frame counter advances only on `frame_tick`. A tick in the same cycle as a state entry counts for the new state.

## Configuration
- **`ROUND_TIMER_EN` defined:**
  - Adds parameter `TIME_FRAMES` (default 5400) and output `time_left` (13 bits).
  - `time_left` loads on FIGHT entry and decrements on each `frame_tick` in FIGHT.
  - When it reaches 0, the block goes to KO. The winner is the lane with the larger `blood`; equal blood is a draw.
  - If `over` and timer expiry occur in the same cycle, `over` takes priority.
- **Undefined:** no round timer; `time_left` is absent; rounds end only on `over`.

## Structure
- **Package `kof_pkg`:**
  - state enum;
  - winner codes (NONE, P1, P2, DRAW);
  - `DMG_W`;
  - a lane-split helper for `blood` / `blood_dec`.
- **Sub-module `hit_accumulator`:**
  - One instance per lane.
  - Saturating add with clear-on-flush; a hit in the flush cycle loads directly, per the Frame flush rule.

## Test plan
- **Reset values:** release reset, then pulse `start` → `keep` = 1 for 60 ticks, then `state` = FIGHT and `keep` = 0.
- **Single hit:** `hit_p1` with `dmg` = 0x0A in FIGHT, then `frame_tick` → `fresh` pulse 1 cycle later with `blood_dec` = 0x000A.
- **Simultaneous hits and saturation:** `hit_p1` and `hit_p2` in the same cycle (0x0A each), then a tick → `blood_dec` = 0x0A0A. Three hits of 0x90 on one lane → that lane = 0xFF.
- **Hit on the flush cycle:** a hit coincident with `frame_tick` → excluded from the current flush, appears in the next `blood_dec`.
- **KO and match end:** `over` with `blood` = 0x3200 → `winner` = 1 and `wins_p1` = 1. A second P1 KO → MATCH_END with `match_done` = 1. A double-KO with `blood` = 0x0000 → `winner` = 3 and no increment.
- **Reset in FIGHT:** assert `reset` low mid-FIGHT with pending damage → all outputs return to reset values and no `fresh` is issued.
